// File: rtl/conv_col_stream_core.sv
// rtl/conv_col_stream_core.sv - column-streamed KxK convolution core
// Accumulates K kernel/pixel column beats into N_OUT vertical window sums.
module conv_col_stream_core #(
   parameter int WIDTH  = 8,
   parameter int ROWS   = 8,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int ACC_W  = 2*WIDTH + $clog2(K*K)
) (
   input  logic                                     clk,
   input  logic                                     rstn,
   input  logic                                     en,
   input  logic                                     i_valid,
   output logic                                     i_ready,
   input  logic [ROWS*WIDTH-1:0]                    i_r,
   input  logic [K*WIDTH-1:0]                       i_f,
   output logic                                     o_valid,
   input  logic                                     o_ready,
   output logic [((ROWS-K)/STRIDE+1)*ACC_W-1:0]     o_sum,
   output logic [$clog2(K):0]                       o_col
);

   localparam int N_OUT = (ROWS - K) / STRIDE + 1;
   localparam int COL_W = $clog2(K) + 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(K - 1);

   logic [2*WIDTH-1:0]     w_prod [N_OUT][K];
   logic [ACC_W-1:0]       w_part [N_OUT];
   logic                   w_acc;
   logic                   w_last;
   logic                   w_ohs;

   logic [COL_W-1:0]       r_col;
   logic [ACC_W-1:0]       r_acc [N_OUT];
   logic [N_OUT*ACC_W-1:0] r_sum;
   logic                   r_valid;

   // Operands zero-extended so the product keeps its full 2*WIDTH bits.
   for (genvar gj = 0; gj < N_OUT; gj++) begin : g_row
      for (genvar gk = 0; gk < K; gk++) begin : g_tap
         assign w_prod[gj][gk] = {{WIDTH{1'b0}}, i_f[gk*WIDTH +: WIDTH]}
                               * {{WIDTH{1'b0}}, i_r[(gj*STRIDE+gk)*WIDTH +: WIDTH]};
      end
   end

   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         w_part[j] = '0;
         for (int k = 0; k < K; k++) begin
            w_part[j] = w_part[j] + ACC_W'(w_prod[j][k]);
         end
      end
   end

   assign i_ready = !r_valid | o_ready;
   assign w_acc   = en & i_valid & i_ready;
   assign w_last  = (r_col == LAST_COL);
   assign w_ohs   = en & r_valid & o_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_col   <= '0;
         r_sum   <= '0;
         r_valid <= 1'b0;
         for (int j = 0; j < N_OUT; j++) begin
            r_acc[j] <= '0;
         end
      end else begin
         if (w_acc) begin
            r_col <= w_last ? '0 : r_col + COL_W'(1);
            // Column 0 overwrites the accumulator, so no clear cycle is needed.
            for (int j = 0; j < N_OUT; j++) begin
               r_acc[j] <= (r_col == '0) ? w_part[j] : r_acc[j] + w_part[j];
               if (w_last) begin
                  r_sum[j*ACC_W +: ACC_W] <= r_acc[j] + w_part[j];
               end
            end
         end
         if (w_acc && w_last) begin
            r_valid <= 1'b1;
         end else if (w_ohs) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_sum   = r_sum;
   assign o_col   = r_col;

endmodule
